// File: rtl/pkt_dmux_pkg.sv
// Shared packet-word definitions for the demux, LCM and MUX.
package pkt_dmux_pkg;

    localparam int WORD_W  = 134;
    localparam int FLAG_HI = 133;
    localparam int FLAG_LO = 132;
    localparam int TAG_HI  = 127;
    localparam int TAG_LO  = 120;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FLAG_ILL  = 2'b00,
        FLAG_HEAD = 2'b01,
        FLAG_TAIL = 2'b10,
        FLAG_BODY = 2'b11
    } flag_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD_LCM,
        ST_FWD_DATA,
        ST_DISCARD
    } state_e;

    // One cycle's worth of output for a port; en=0 means the port is idle.
    typedef struct packed {
        logic  en;
        word_t data;
        logic  wr;
        logic  valid;
        logic  valid_wr;
    } port_req_t;

    function automatic flag_e word_flag(input word_t w);
        return flag_e'(w[FLAG_HI:FLAG_LO]);
    endfunction

    function automatic logic [7:0] word_tag(input word_t w);
        return w[TAG_HI:TAG_LO];
    endfunction

endpackage

// File: rtl/pkt_dmux_if.sv
// Packet word stream: data with word/end-of-packet strobes and packet-level ready.
interface pkt_dmux_if;
    import pkt_dmux_pkg::*;

    word_t data;
    logic  data_wr;
    logic  data_valid;
    logic  data_valid_wr;
    logic  data_ready;

    modport master (output data, data_wr, data_valid, data_valid_wr, input  data_ready);
    modport slave  (input  data, data_wr, data_valid, data_valid_wr, output data_ready);

endinterface

// File: rtl/pkt_dmux_out_reg.sv
// Per-port output register: strobes pulse for one cycle, data bus holds its last word.
module pkt_out_reg
    import pkt_dmux_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  port_req_t req,
    output word_t     data,
    output logic      wr,
    output logic      valid,
    output logic      valid_wr
);

    // Register the strobes every cycle; load data only when a word is actually written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            wr       <= 1'b0;
            valid    <= 1'b0;
            valid_wr <= 1'b0;
        end else begin
            wr       <= req.en & req.wr;
            valid    <= req.en & req.valid;
            valid_wr <= req.en & req.valid_wr;
            if (req.en && req.wr)
                data <= req.data;
        end
    end

endmodule

// File: rtl/pkt_dmux.sv
// Steers control packets (head tag == CTL_TAG) to the LCM and everything else to
// the data path, with framing-error recovery and per-port packet counters.
module pkt_dmux
    import pkt_dmux_pkg::*;
#(
    parameter logic [7:0] CTL_TAG = 8'h01,
    parameter int         CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pkt_dmux_if.slave        in_dmux,
    pkt_dmux_if.master       lcm,
    pkt_dmux_if.master       fwd,
    output logic [CNT_W-1:0] lcm_pkt_cnt,
    output logic [CNT_W-1:0] fwd_pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    state_e    state, state_nxt;
    logic      bad_q, bad_nxt;     // valid_wr seen on a body word of the current packet
    logic      ready_q;
    port_req_t req, lcm_req, fwd_req;
    logic      to_lcm, pkt_inc, err_inc;

    word_t     in_word;
    flag_e     in_flag;
    logic      in_wr, in_vld, in_vwr, is_ctl;

    assign in_word = in_dmux.data;
    assign in_flag = word_flag(in_word);
    assign in_wr   = in_dmux.data_wr;
    assign in_vld  = in_dmux.data_valid;
    assign in_vwr  = in_dmux.data_valid_wr;
    assign is_ctl  = (word_tag(in_word) == CTL_TAG);

    // State register plus the sticky bad-packet flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            bad_q <= 1'b0;
        end else begin
            state <= state_nxt;
            bad_q <= bad_nxt;
        end
    end

    // Next-state: heads open a packet, tails close it, stray heads/illegal words abort.
    always_comb begin
        state_nxt = state;
        bad_nxt   = bad_q;
        case (state)
            ST_IDLE: begin
                if (in_wr && in_flag == FLAG_HEAD) begin
                    state_nxt = is_ctl ? ST_FWD_LCM : ST_FWD_DATA;
                    bad_nxt   = 1'b0;
                end
            end
            ST_FWD_LCM, ST_FWD_DATA: begin
                if (in_wr) begin
                    case (in_flag)
                        FLAG_BODY: if (in_vwr) bad_nxt = 1'b1;
                        FLAG_TAIL: begin
                            state_nxt = ST_IDLE;
                            bad_nxt   = 1'b0;
                        end
                        default: begin
                            state_nxt = ST_DISCARD;
                            bad_nxt   = 1'b0;
                        end
                    endcase
                end
            end
            default: begin
                if (in_wr && in_flag == FLAG_TAIL)
                    state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: build the one port request for this cycle and the counter bumps.
    always_comb begin
        req     = '0;
        to_lcm  = 1'b0;
        pkt_inc = 1'b0;
        err_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                to_lcm  = is_ctl;
                err_inc = (in_wr && in_flag != FLAG_HEAD) || in_vwr;
                if (in_wr && in_flag == FLAG_HEAD) begin
                    req.en   = 1'b1;
                    req.wr   = 1'b1;
                    req.data = in_word;
                end
            end
            ST_FWD_LCM, ST_FWD_DATA: begin
                to_lcm = (state == ST_FWD_LCM);
                if (in_wr) begin
                    req.en   = 1'b1;
                    req.data = in_word;
                    case (in_flag)
                        FLAG_BODY: req.wr = 1'b1;
                        FLAG_TAIL: begin
                            req.wr       = 1'b1;
                            req.valid_wr = 1'b1;
                            req.valid    = in_vld & in_vwr & ~bad_q;
                            pkt_inc      = 1'b1;
                            err_inc      = ~in_vwr | bad_q;
                        end
                        default: begin
                            // Close the open packet as bad; the offending word is dropped.
                            req.valid_wr = 1'b1;
                            err_inc      = 1'b1;
                        end
                    endcase
                end
            end
            default: ;
        endcase
        lcm_req = to_lcm ? req : '0;
        fwd_req = to_lcm ? '0  : req;
    end

    // Admission: only between packets, and only when both destinations can take a packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ready_q <= 1'b0;
        else
            ready_q <= lcm.data_ready & fwd.data_ready & (state == ST_IDLE);
    end

    assign in_dmux.data_ready = ready_q;

    // Statistics counters, free-running modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcm_pkt_cnt <= '0;
            fwd_pkt_cnt <= '0;
            err_cnt     <= '0;
        end else begin
            if (pkt_inc && to_lcm)  lcm_pkt_cnt <= lcm_pkt_cnt + CNT_W'(1);
            if (pkt_inc && !to_lcm) fwd_pkt_cnt <= fwd_pkt_cnt + CNT_W'(1);
            if (err_inc)            err_cnt     <= err_cnt + CNT_W'(1);
        end
    end

    pkt_out_reg u_lcm_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (lcm_req),
        .data     (lcm.data),
        .wr       (lcm.data_wr),
        .valid    (lcm.data_valid),
        .valid_wr (lcm.data_valid_wr)
    );

    pkt_out_reg u_fwd_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (fwd_req),
        .data     (fwd.data),
        .wr       (fwd.data_wr),
        .valid    (fwd.data_valid),
        .valid_wr (fwd.data_valid_wr)
    );

endmodule

// File: tb/tb_pkt_dmux.sv
// Scoreboard bench for pkt_dmux: stimulus pushes expected port outputs, a monitor pops them.
module tb_pkt_dmux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] lcm_cnt, fwd_cnt, err_cnt;

    pkt_dmux_if in_if();
    pkt_dmux_if lcm_if();
    pkt_dmux_if fwd_if();

    pkt_dmux #(.CTL_TAG(8'h01), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_dmux     (in_if),
        .lcm         (lcm_if),
        .fwd         (fwd_if),
        .lcm_pkt_cnt (lcm_cnt),
        .fwd_pkt_cnt (fwd_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [133:0] data;
        logic         wr;
        logic         valid;
        logic         vwr;
    } exp_t;

    exp_t exp_lcm[$];
    exp_t exp_fwd[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   seq     = 0;

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [133:0] mkw(input logic [1:0] flag, input logic [7:0] tag);
        seq++;
        return {flag, 4'hC, tag, 56'h0, 32'hDEAD0000, 32'(seq)};
    endfunction

    task automatic set_idle();
        in_if.data_wr       = 1'b0;
        in_if.data_valid    = 1'b0;
        in_if.data_valid_wr = 1'b0;
    endtask

    task automatic drive(input logic [133:0] w, input logic v, input logic vw);
        @(negedge clk);
        in_if.data          = w;
        in_if.data_wr       = 1'b1;
        in_if.data_valid    = v;
        in_if.data_valid_wr = vw;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            set_idle();
        end
    endtask

    task automatic push(input bit to_lcm, input logic [133:0] d, input logic wr,
                        input logic v, input logic vw);
        exp_t e;
        e.data = d; e.wr = wr; e.valid = v; e.vwr = vw;
        if (to_lcm) exp_lcm.push_back(e);
        else        exp_fwd.push_back(e);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            set_idle();
            if (in_if.data_ready === 1'b1) return;
        end
        chk("ready_timeout", 134'(in_if.data_ready), 134'(1));
    endtask

    // n-word packet; tail carries valid=v, valid_wr=vw. to_lcm is the hand-chosen destination.
    task automatic send_pkt(input logic [7:0] tag, input int n, input logic v,
                            input logic vw, input bit to_lcm);
        logic [133:0] w;
        for (int i = 0; i < n; i++) begin
            if (i == 0)          w = mkw(2'b01, tag);
            else if (i == n - 1) w = mkw(2'b10, tag);
            else                 w = mkw(2'b11, tag);
            if (i == n - 1) begin
                push(to_lcm, w, 1'b1, v & vw, 1'b1);
                drive(w, v, vw);
            end else begin
                push(to_lcm, w, 1'b1, 1'b0, 1'b0);
                drive(w, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic mon_port(input string nm, input bit is_lcm, input logic [133:0] d,
                            input logic wr, input logic v, input logic vw);
        exp_t e;
        if (is_lcm ? exp_lcm.size() == 0 : exp_fwd.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s_unexpected: got wr=%0b valid=%0b valid_wr=%0b data=%h, expected no output",
                     nm, wr, v, vw, d);
            return;
        end
        e = is_lcm ? exp_lcm.pop_front() : exp_fwd.pop_front();
        chk({nm, "_strobes"}, 134'({wr, v, vw}), 134'({e.wr, e.valid, e.vwr}));
        if (e.wr) chk({nm, "_data"}, d, e.data);
    endtask

    // Monitor: whenever a port presents a word or end-of-packet, compare against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (lcm_if.data_wr || lcm_if.data_valid_wr)
                mon_port("lcm", 1'b1, lcm_if.data, lcm_if.data_wr, lcm_if.data_valid, lcm_if.data_valid_wr);
            if (fwd_if.data_wr || fwd_if.data_valid_wr)
                mon_port("fwd", 1'b0, fwd_if.data, fwd_if.data_wr, fwd_if.data_valid, fwd_if.data_valid_wr);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [133:0] w;
        in_if.data = '0;
        set_idle();
        lcm_if.data_ready = 1'b1;
        fwd_if.data_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 134'(in_if.data_ready), 134'(0));
        chk("rst_lcm_strobes", 134'({lcm_if.data_wr, lcm_if.data_valid, lcm_if.data_valid_wr}), 134'(0));
        chk("rst_fwd_strobes", 134'({fwd_if.data_wr, fwd_if.data_valid, fwd_if.data_valid_wr}), 134'(0));
        chk("rst_lcm_data", lcm_if.data, 134'(0));
        chk("rst_cnts", 134'({lcm_cnt, fwd_cnt, err_cnt}), 134'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 134'(in_if.data_ready), 134'(1));

        // Control packet, 6 words
        send_pkt(8'h01, 6, 1'b1, 1'b1, 1'b1);
        idle(2);
        chk("ctl_lcm_cnt", 134'(lcm_cnt), 134'(1));
        chk("ctl_fwd_cnt", 134'(fwd_cnt), 134'(0));

        // Data packet, 7 words
        wait_ready();
        send_pkt(8'h15, 7, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("data_fwd_cnt", 134'(fwd_cnt), 134'(1));
        chk("data_lcm_cnt", 134'(lcm_cnt), 134'(1));

        // Back-to-back two-word packets alternating destinations
        wait_ready();
        send_pkt(8'h01, 2, 1'b1, 1'b1, 1'b1);
        send_pkt(8'h15, 2, 1'b1, 1'b1, 1'b0);
        send_pkt(8'h01, 2, 1'b0, 1'b1, 1'b1);
        send_pkt(8'h15, 2, 1'b1, 1'b1, 1'b0);
        idle(2);
        chk("b2b_lcm_cnt", 134'(lcm_cnt), 134'(3));
        chk("b2b_fwd_cnt", 134'(fwd_cnt), 134'(3));
        chk("b2b_err_cnt", 134'(err_cnt), 134'(0));

        // Ready follows destination ready with one cycle delay
        wait_ready();
        lcm_if.data_ready = 1'b0;
        @(negedge clk);
        chk("ready_drop", 134'(in_if.data_ready), 134'(0));
        lcm_if.data_ready = 1'b1;
        @(negedge clk);
        chk("ready_restore", 134'(in_if.data_ready), 134'(1));

        // Head injected at word 4 of a control packet
        w = mkw(2'b01, 8'h01); push(1'b1, w, 1'b1, 1'b0, 1'b0); drive(w, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            w = mkw(2'b11, 8'h01); push(1'b1, w, 1'b1, 1'b0, 1'b0); drive(w, 1'b0, 1'b0);
        end
        w = mkw(2'b01, 8'h15); push(1'b1, w, 1'b0, 1'b0, 1'b1); drive(w, 1'b0, 1'b0);
        drive(mkw(2'b11, 8'h15), 1'b0, 1'b0);
        drive(mkw(2'b11, 8'h15), 1'b0, 1'b0);
        drive(mkw(2'b10, 8'h15), 1'b1, 1'b1);
        idle(2);
        chk("inject_err_cnt", 134'(err_cnt), 134'(1));
        chk("inject_lcm_cnt", 134'(lcm_cnt), 134'(3));
        chk("inject_fwd_cnt", 134'(fwd_cnt), 134'(3));

        // Stray body in IDLE, then a data tail missing valid_wr
        wait_ready();
        drive(mkw(2'b11, 8'h15), 1'b0, 1'b0);
        idle(1);
        chk("stray_err_cnt", 134'(err_cnt), 134'(2));
        wait_ready();
        send_pkt(8'h15, 3, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("novwr_err_cnt", 134'(err_cnt), 134'(3));

        // Reset pulse mid-packet
        wait_ready();
        w = mkw(2'b01, 8'h01); push(1'b1, w, 1'b1, 1'b0, 1'b0); drive(w, 1'b0, 1'b0);
        w = mkw(2'b11, 8'h01); drive(w, 1'b0, 1'b0);
        #7;
        set_idle();
        rst_n = 1'b0;
        #2;
        chk("midrst_lcm", 134'({lcm_if.data_wr, lcm_if.data_valid, lcm_if.data_valid_wr}), 134'(0));
        chk("midrst_lcm_data", lcm_if.data, 134'(0));
        chk("midrst_cnts", 134'({lcm_cnt, fwd_cnt, err_cnt}), 134'(0));
        chk("midrst_ready", 134'(in_if.data_ready), 134'(0));
        #3;
        rst_n = 1'b1;
        wait_ready();
        send_pkt(8'h01, 3, 1'b1, 1'b1, 1'b1);
        idle(3);
        chk("post_rst_lcm_cnt", 134'(lcm_cnt), 134'(1));
        chk("post_rst_other", 134'({fwd_cnt, err_cnt}), 134'(0));
        chk("scoreboard_drained", 134'(exp_lcm.size() + exp_fwd.size()), 134'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
